oram_client_arbiter: RTL and testbench

- Parametrised N-client front door for one TinyORAM core instance: round-robin arbitration of commands from NumClients independent requesters.
- Streams each granted command's block data between the owning client and the core's DataIn/DataOut ports.
- Sits directly above the ORAM core top.
- Generalises the single-user interface to multiple channels, with optional per-client address-space isolation.

---
 rtl/oram_client_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_oram_client_arbiter.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oram_client_arbiter.sv
// oram_client_arbiter
// N-client front door for a single TinyORAM core. Commands from NumClients
// requesters are arbitrated round-robin. Only one command is outstanding at a
// time. The granted client's block data is streamed to or from the core's
// DataIn/DataOut ports with no added latency.
//
// Optional build macro: ORAM_ARB_PARTITION_EN
//   Defined   : the core address is {Owner, low bits of the client address}.
//               Each client then gets a disjoint 1/NumClients slice of the
//               ORAM address space.
//   Undefined : the client address is forwarded unmodified, so all clients
//               share one address space.
module oram_client_arbiter #(
   parameter int NumClients = 4,
   parameter int ORAMU      = 32,
   parameter int ORAMB      = 512,
   parameter int FEDWidth   = 64,
   parameter int BECMDWidth = 2,
   parameter int IDWidth    = $clog2(NumClients)
) (
   input  logic                             Clock,
   input  logic                             Reset,
   // client side
   input  logic [NumClients*BECMDWidth-1:0] CCmd,
   input  logic [NumClients*ORAMU-1:0]      CPAddr,
   input  logic [NumClients-1:0]            CCmdValid,
   output logic [NumClients-1:0]            CCmdReady,
   input  logic [NumClients*FEDWidth-1:0]   CDataIn,
   input  logic [NumClients-1:0]            CDataInValid,
   output logic [NumClients-1:0]            CDataInReady,
   output logic [FEDWidth-1:0]              CDataOut,
   output logic [NumClients-1:0]            CDataOutValid,
   input  logic [NumClients-1:0]            CDataOutReady,
   // core side
   output logic [BECMDWidth-1:0]            Cmd,
   output logic [ORAMU-1:0]                 PAddr,
   output logic                             CmdValid,
   input  logic                             CmdReady,
   output logic [FEDWidth-1:0]              DataIn,
   output logic                             DataInValid,
   input  logic                             DataInReady,
   input  logic [FEDWidth-1:0]              DataOut,
   input  logic                             DataOutValid,
   output logic                             DataOutReady,
   // status
   output logic [IDWidth-1:0]               Owner,
   output logic                             Busy
);

   localparam int Beats        = ORAMB / FEDWidth;
   // One spare bit so the counter can never wrap inside a burst.
   localparam int BeatCntWidth = $clog2(Beats) + 1;
   localparam logic [BeatCntWidth-1:0] LastBeat = BeatCntWidth'(Beats - 1);

   typedef enum logic [1:0] {
      ST_Idle,
      ST_Cmd,
      ST_Write,
      ST_Read
   } stateType;

   stateType                 state;
   stateType                 nextState;
   logic [BeatCntWidth-1:0]  beatCnt;
   logic [IDWidth-1:0]       owner;
   logic [IDWidth-1:0]       lastGrant;
   logic [BECMDWidth-1:0]    cmdReg;
   logic [ORAMU-1:0]         pAddrReg;

   logic                     grantValid;
   logic [IDWidth-1:0]       grantId;
   logic [IDWidth-1:0]       candidate;
   logic [BECMDWidth-1:0]    grantCmd;
   logic [ORAMU-1:0]         grantAddr;

   logic                     wrFire;
   logic                     rdFire;
   logic                     onLastBeat;

   // Round-robin search starting just after the previous winner, wrapping.
   // NOTE: every signal written here gets a default first; a path that skips
   // an assignment in always_comb would otherwise infer a latch.
   always_comb begin
      grantValid = 1'b0;
      grantId    = '0;
      candidate  = '0;
      for (int k = 1; k <= NumClients; k++) begin
         // NumClients is a power of two, so IDWidth-bit addition wraps correctly.
         candidate = lastGrant + IDWidth'(k);
         if (!grantValid && CCmdValid[candidate]) begin
            grantValid = 1'b1;
            grantId    = candidate;
         end
      end
   end

   assign grantCmd = CCmd[grantId*BECMDWidth +: BECMDWidth];

`ifdef ORAM_ARB_PARTITION_EN
   // The client's upper IDWidth address bits are replaced by its own ID.
   assign grantAddr = {grantId, CPAddr[grantId*ORAMU +: ORAMU-IDWidth]};
`else
   assign grantAddr = CPAddr[grantId*ORAMU +: ORAMU];
`endif

   assign wrFire     = (state == ST_Write) && CDataInValid[owner] && DataInReady;
   assign rdFire     = (state == ST_Read) && DataOutValid && CDataOutReady[owner];
   assign onLastBeat = (beatCnt == LastBeat);

   // State register.
   // NOTE: sequential state uses non-blocking assignments only. All flops then
   // update together at the edge, whatever order the blocks are evaluated in.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state <= ST_Idle;
      else       state <= nextState;
   end

   // Next-state logic plus all handshake and data routing, decoded from state.
   always_comb begin
      nextState     = state;
      CCmdReady     = '0;
      CmdValid      = 1'b0;
      DataIn        = '0;
      DataInValid   = 1'b0;
      CDataInReady  = '0;
      CDataOut      = '0;
      CDataOutValid = '0;
      DataOutReady  = 1'b0;
      unique case (state)
         ST_Idle: begin
            // A grant is withheld during reset so no client sees a phantom accept.
            if (grantValid && !Reset) begin
               CCmdReady[grantId] = 1'b1;
               nextState          = ST_Cmd;
            end
         end
         ST_Cmd: begin
            CmdValid = 1'b1;
            if (CmdReady) nextState = cmdReg[1] ? ST_Read : ST_Write;
         end
         ST_Write: begin
            DataIn              = CDataIn[owner*FEDWidth +: FEDWidth];
            DataInValid         = CDataInValid[owner];
            CDataInReady[owner] = DataInReady;
            if (wrFire && onLastBeat) nextState = ST_Idle;
         end
         ST_Read: begin
            CDataOut             = DataOut;
            CDataOutValid[owner] = DataOutValid;
            DataOutReady         = CDataOutReady[owner];
            if (rdFire && onLastBeat) nextState = ST_Idle;
         end
         default: nextState = ST_Idle;
      endcase
   end

   // Capture the winner's command and address, and remember it for round-robin.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         owner     <= '0;
         lastGrant <= IDWidth'(NumClients - 1);
         cmdReg    <= '0;
         pAddrReg  <= '0;
      end else if ((state == ST_Idle) && grantValid) begin
         owner     <= grantId;
         lastGrant <= grantId;
         cmdReg    <= grantCmd;
         pAddrReg  <= grantAddr;
      end
   end

   // Beat counter: cleared when the core accepts the command, then counts handshakes.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)                                beatCnt <= '0;
      else if ((state == ST_Cmd) && CmdReady)   beatCnt <= '0;
      else if (wrFire || rdFire)                beatCnt <= beatCnt + BeatCntWidth'(1);
   end

   assign Cmd   = cmdReg;
   assign PAddr = pAddrReg;
   assign Owner = owner;
   assign Busy  = (state != ST_Idle);

endmodule

// File: tb/tb_oram_client_arbiter.sv
// tb_oram_client_arbiter
// Directed bench for oram_client_arbiter with scoreboard checking.
// The stimulus pushes the expected grants, core commands and data beats into
// queues. A monitor then pops and compares them whenever the DUT presents a
// handshake. Honours ORAM_ARB_PARTITION_EN for the expected core address.
module tb_oram_client_arbiter;

   localparam int NC    = 4;
   localparam int U     = 32;
   localparam int B     = 512;
   localparam int FW    = 64;
   localparam int CW    = 2;
   localparam int IW    = 2;
   localparam int BEATS = B / FW;

`ifdef ORAM_ARB_PARTITION_EN
   localparam bit Partition = 1'b1;
`else
   localparam bit Partition = 1'b0;
`endif

   logic              Clock = 1'b0;
   logic              Reset;
   logic [NC*CW-1:0]  CCmd;
   logic [NC*U-1:0]   CPAddr;
   logic [NC-1:0]     CCmdValid;
   logic [NC-1:0]     CCmdReady;
   logic [NC*FW-1:0]  CDataIn;
   logic [NC-1:0]     CDataInValid;
   logic [NC-1:0]     CDataInReady;
   logic [FW-1:0]     CDataOut;
   logic [NC-1:0]     CDataOutValid;
   logic [NC-1:0]     CDataOutReady;
   logic [CW-1:0]     Cmd;
   logic [U-1:0]      PAddr;
   logic              CmdValid;
   logic              CmdReady;
   logic [FW-1:0]     DataIn;
   logic              DataInValid;
   logic              DataInReady;
   logic [FW-1:0]     DataOut;
   logic              DataOutValid;
   logic              DataOutReady;
   logic [IW-1:0]     Owner;
   logic              Busy;

   oram_client_arbiter #(
      .NumClients(NC), .ORAMU(U), .ORAMB(B), .FEDWidth(FW), .BECMDWidth(CW), .IDWidth(IW)
   ) dut (
      .Clock(Clock), .Reset(Reset),
      .CCmd(CCmd), .CPAddr(CPAddr), .CCmdValid(CCmdValid), .CCmdReady(CCmdReady),
      .CDataIn(CDataIn), .CDataInValid(CDataInValid), .CDataInReady(CDataInReady),
      .CDataOut(CDataOut), .CDataOutValid(CDataOutValid), .CDataOutReady(CDataOutReady),
      .Cmd(Cmd), .PAddr(PAddr), .CmdValid(CmdValid), .CmdReady(CmdReady),
      .DataIn(DataIn), .DataInValid(DataInValid), .DataInReady(DataInReady),
      .DataOut(DataOut), .DataOutValid(DataOutValid), .DataOutReady(DataOutReady),
      .Owner(Owner), .Busy(Busy)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [CW-1:0] cmd;
      logic [U-1:0]  addr;
   } cmdT;

   typedef struct {
      int            client;
      logic [FW-1:0] data;
   } beatT;

   // client-side stimulus queues
   cmdT           cmdQ[NC][$];
   logic [FW-1:0] wrQ[NC][$];

   // scoreboard
   int   expGrantQ[$];
   cmdT  expCmdQ[$];
   beatT expWrQ[$];
   beatT expRdQ[$];

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [U-1:0] expAddr(input int id, input logic [U-1:0] a);
      logic [IW-1:0] idBits;
      idBits = IW'(id);
      return Partition ? {idBits, a[U-IW-1:0]} : a;
   endfunction

   function automatic bit allIdle();
      bit e;
      e = (expGrantQ.size() == 0) && (expCmdQ.size() == 0) &&
          (expWrQ.size() == 0) && (expRdQ.size() == 0) && !Busy;
      for (int i = 0; i < NC; i++) e = e && (cmdQ[i].size() == 0) && (wrQ[i].size() == 0);
      return e;
   endfunction

   task automatic tick();
      @(posedge Clock);
      #2;
   endtask

   task automatic issueCmd(input int id, input logic [CW-1:0] c, input logic [U-1:0] a);
      cmdT x;
      x.cmd  = c;
      x.addr = a;
      cmdQ[id].push_back(x);
   endtask

   task automatic issueWrite(input int id, input logic [U-1:0] a, input logic [FW-1:0] base);
      issueCmd(id, 2'd0, a);
      for (int b = 0; b < BEATS; b++) wrQ[id].push_back(base + FW'(b));
   endtask

   task automatic expectWrite(input int id, input logic [U-1:0] a, input logic [FW-1:0] base);
      cmdT  x;
      beatT e;
      expGrantQ.push_back(id);
      x.cmd  = 2'd0;
      x.addr = expAddr(id, a);
      expCmdQ.push_back(x);
      for (int b = 0; b < BEATS; b++) begin
         e.client = id;
         e.data   = base + FW'(b);
         expWrQ.push_back(e);
      end
   endtask

   task automatic expectRead(input int id, input logic [CW-1:0] c, input logic [U-1:0] a,
                             input logic [FW-1:0] base);
      cmdT  x;
      beatT e;
      expGrantQ.push_back(id);
      x.cmd  = c;
      x.addr = expAddr(id, a);
      expCmdQ.push_back(x);
      for (int b = 0; b < BEATS; b++) begin
         e.client = id;
         e.data   = base + FW'(b);
         expRdQ.push_back(e);
      end
   endtask

   task automatic waitDrain(input string name);
      int n;
      bit done;
      n    = 0;
      done = 1'b0;
      while (!done && n < 600) begin
         @(negedge Clock);
         n++;
         done = allIdle();
      end
      check({name, "_drained"}, done, 1);
      tick();
   endtask

   // Client agents: present the queue heads and retire entries on handshakes.
   initial begin
      logic [NC-1:0] cf;
      logic [NC-1:0] wf;
      CCmdValid    = '0;
      CCmd         = '0;
      CPAddr       = '0;
      CDataIn      = '0;
      CDataInValid = '0;
      forever begin
         @(negedge Clock);
         cf = CCmdValid & CCmdReady;
         wf = CDataInValid & CDataInReady;
         @(posedge Clock);
         #1;
         for (int i = 0; i < NC; i++) begin
            if (cf[i] && cmdQ[i].size() > 0) void'(cmdQ[i].pop_front());
            if (wf[i] && wrQ[i].size() > 0) void'(wrQ[i].pop_front());
            CCmdValid[i]    = (cmdQ[i].size() > 0);
            CCmd[i*CW +: CW] = (cmdQ[i].size() > 0) ? cmdQ[i][0].cmd : '0;
            CPAddr[i*U +: U] = (cmdQ[i].size() > 0) ? cmdQ[i][0].addr : '0;
            CDataInValid[i] = (wrQ[i].size() > 0);
            CDataIn[i*FW +: FW] = (wrQ[i].size() > 0) ? wrQ[i][0] : '0;
         end
      end
   end

   // Core read model: the k-th read command returns beats 0xA0+16*k+b.
   initial begin
      int k;
      int w;
      k            = 0;
      DataOut      = '0;
      DataOutValid = 1'b0;
      forever begin
         @(negedge Clock);
         if (!Reset && CmdValid && CmdReady && Cmd[1]) begin
            @(posedge Clock);
            #1;
            for (int b = 0; b < BEATS; b++) begin
               DataOut      = FW'(32'hA0 + 16 * k + b);
               DataOutValid = 1'b1;
               @(negedge Clock);
               w = 0;
               while (!DataOutReady && w < 200) begin
                  @(negedge Clock);
                  w++;
               end
               if (w >= 200) begin
                  check("core_read_ready_timeout", w, 0);
                  break;
               end
               @(posedge Clock);
               #1;
            end
            DataOutValid = 1'b0;
            DataOut      = '0;
            k++;
         end
      end
   end

   // Monitor: compares DUT outputs against the scoreboard on every falling edge.
   initial begin
      bit            prevGrant;
      int            prevGrantId;
      bit            prevLast;
      int            beatCount;
      int            g;
      logic [NC-1:0] oh;
      cmdT           x;
      beatT          e;
      prevGrant   = 1'b0;
      prevGrantId = 0;
      prevLast    = 1'b0;
      beatCount   = 0;
      forever begin
         @(negedge Clock);
         if (Reset) begin
            prevGrant = 1'b0;
            prevLast  = 1'b0;
            beatCount = 0;
            continue;
         end
         if (prevGrant) begin
            check("cmdvalid_latency", CmdValid, 1);
            check("owner_after_grant", Owner, prevGrantId);
         end
         if (prevLast) check("busy_after_last_beat", Busy, 0);
         prevGrant = 1'b0;
         prevLast  = 1'b0;

         if (Busy && CCmdValid != '0) check("no_grant_while_busy", CCmdReady, 0);

         if (CCmdReady != '0) begin
            if (expGrantQ.size() == 0) check("unexpected_grant", CCmdReady, 0);
            else begin
               g     = expGrantQ.pop_front();
               oh    = '0;
               oh[g] = 1'b1;
               check("grant_onehot", CCmdReady, oh);
               prevGrant   = 1'b1;
               prevGrantId = g;
            end
         end

         if (CmdValid) begin
            if (expCmdQ.size() == 0) check("unexpected_cmdvalid", CmdValid, 0);
            else begin
               x = expCmdQ[0];
               check("core_cmd", Cmd, x.cmd);
               check("core_paddr", PAddr, x.addr);
               if (CmdReady) void'(expCmdQ.pop_front());
            end
         end

         if (DataInValid && DataInReady) begin
            if (expWrQ.size() == 0) check("unexpected_write_beat", DataIn, 0);
            else begin
               e         = expWrQ.pop_front();
               oh        = '0;
               oh[e.client] = 1'b1;
               check("write_data", DataIn, e.data);
               check("write_ready_owner", CDataInReady, oh);
               beatCount++;
               if (beatCount == BEATS) begin
                  prevLast  = 1'b1;
                  beatCount = 0;
               end
            end
         end

         if (CDataOutValid != '0) begin
            if (expRdQ.size() == 0) check("unexpected_read_valid", CDataOutValid, 0);
            else begin
               e            = expRdQ[0];
               oh           = '0;
               oh[e.client] = 1'b1;
               check("read_valid_owner", CDataOutValid, oh);
               check("read_ready_pass", DataOutReady, CDataOutReady[e.client]);
               if (CDataOutValid[e.client] && CDataOutReady[e.client]) begin
                  void'(expRdQ.pop_front());
                  check("read_data", CDataOut, e.data);
                  beatCount++;
                  if (beatCount == BEATS) begin
                     prevLast  = 1'b1;
                     beatCount = 0;
                  end
               end
            end
         end
      end
   end

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Directed stimulus.
   initial begin
      int cnt;
      int n;
      Reset         = 1'b0;
      CmdReady      = 1'b1;
      DataInReady   = 1'b1;
      CDataOutReady = '1;
      #1;
      Reset = 1'b1;
      repeat (3) @(posedge Clock);
      #2;
      check("rst_busy", Busy, 0);
      check("rst_cmdvalid", CmdValid, 0);
      check("rst_owner", Owner, 0);
      check("rst_cmd", Cmd, 0);
      check("rst_paddr", PAddr, 0);
      check("rst_ccmdready", CCmdReady, 0);
      Reset = 1'b0;
      tick();
      tick();
      check("idle_no_req_busy", Busy, 0);
      check("idle_no_req_ready", CCmdReady, 0);

      // Single write from client 2.
      expectWrite(2, 32'h40, 64'h1);
      issueWrite(2, 32'h40, 64'h1);
      waitDrain("single_write");

      // Read return to client 1, with the client stalling 3 cycles mid-burst.
      expectRead(1, 2'd2, 32'h100, 64'hA0);
      issueCmd(1, 2'd2, 32'h100);
      cnt = 0;
      n   = 0;
      while (cnt < 3 && n < 200) begin
         @(negedge Clock);
         n++;
         if (CDataOutValid[1] && CDataOutReady[1]) cnt++;
      end
      check("read_reached_beat3", cnt, 3);
      @(posedge Clock);
      #2;
      CDataOutReady[1] = 1'b0;
      for (int s = 0; s < 3; s++) begin
         @(negedge Clock);
         check("stall_dataoutready", DataOutReady, 0);
         check("stall_valid_held", CDataOutValid, 4'b0010);
      end
      @(posedge Clock);
      #2;
      CDataOutReady[1] = 1'b1;
      waitDrain("read_return");

      // Round-robin after reset: grant order 0,1,2,3,0.
      Reset = 1'b1;
      tick();
      tick();
      Reset = 1'b0;
      tick();
      expectRead(0, 2'd2, 32'h10, 64'hB0);
      expectRead(1, 2'd3, 32'h20, 64'hC0);
      expectRead(2, 2'd2, 32'h30, 64'hD0);
      expectRead(3, 2'd3, 32'h40, 64'hE0);
      expectRead(0, 2'd2, 32'h14, 64'hF0);
      issueCmd(0, 2'd2, 32'h10);
      issueCmd(0, 2'd2, 32'h14);
      issueCmd(1, 2'd3, 32'h20);
      issueCmd(2, 2'd2, 32'h30);
      issueCmd(3, 2'd3, 32'h40);
      waitDrain("round_robin");

      // Owner re-request: client 3 asks again during its own burst, client 0 waits.
      expectWrite(3, 32'h300, 64'h31);
      expectWrite(0, 32'h0AA, 64'h11);
      expectWrite(3, 32'h304, 64'h41);
      issueWrite(3, 32'h300, 64'h31);
      n = 0;
      while (!(DataInValid && DataInReady) && n < 100) begin
         @(negedge Clock);
         n++;
      end
      check("rerequest_burst_started", DataInValid && DataInReady, 1);
      tick();
      issueWrite(3, 32'h304, 64'h41);
      issueWrite(0, 32'h0AA, 64'h11);
      waitDrain("owner_rerequest");

      // Core command backpressure.
      CmdReady = 1'b0;
      expectWrite(1, 32'h500, 64'h51);
      expectWrite(2, 32'h600, 64'h61);
      issueWrite(1, 32'h500, 64'h51);
      issueWrite(2, 32'h600, 64'h61);
      n = 0;
      while (!CmdValid && n < 50) begin
         @(negedge Clock);
         n++;
      end
      check("bp_cmdvalid_seen", CmdValid, 1);
      for (int s = 0; s < 10; s++) begin
         @(negedge Clock);
         check("bp_cmdvalid", CmdValid, 1);
         check("bp_cmd", Cmd, 0);
         check("bp_paddr", PAddr, expAddr(1, 32'h500));
         check("bp_no_other_grant", CCmdReady, 0);
      end
      @(posedge Clock);
      #2;
      CmdReady = 1'b1;
      waitDrain("backpressure");

      // Reset in the middle of a client-0 write burst.
      expectWrite(0, 32'h700, 64'h71);
      issueWrite(0, 32'h700, 64'h71);
      cnt = 0;
      n   = 0;
      while (cnt < 4 && n < 100) begin
         @(negedge Clock);
         n++;
         if (DataInValid && DataInReady) cnt++;
      end
      check("midburst_reached_beat4", cnt, 4);
      @(posedge Clock);
      #2;
      Reset = 1'b1;
      #1;
      check("mid_rst_busy", Busy, 0);
      check("mid_rst_cmdvalid", CmdValid, 0);
      check("mid_rst_datainvalid", DataInValid, 0);
      check("mid_rst_datain", DataIn, 0);
      check("mid_rst_cdatainready", CDataInReady, 0);
      check("mid_rst_ccmdready", CCmdReady, 0);
      check("mid_rst_cdataoutvalid", CDataOutValid, 0);
      check("mid_rst_dataoutready", DataOutReady, 0);
      check("mid_rst_cmd_paddr", {Cmd, PAddr}, 0);
      check("mid_rst_owner", Owner, 0);
      expWrQ.delete();
      wrQ[0].delete();
      @(posedge Clock);
      #2;
      Reset = 1'b0;
      tick();
      expectWrite(0, 32'h710, 64'h81);
      expectWrite(1, 32'h720, 64'h91);
      issueWrite(1, 32'h720, 64'h91);
      issueWrite(0, 32'h710, 64'h81);
      waitDrain("after_reset");

      check("leftover_expectations",
            expGrantQ.size() + expCmdQ.size() + expWrQ.size() + expRdQ.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
